// File: rtl/beat_sequencer.sv
// beat_sequencer: tempo-driven melody table player with articulation gap; `BEAT_SEQ_LOOP_EN repeats the song until stop
module beat_sequencer #(
  parameter int AW       = 6,
  parameter int TONE_W   = 32,
  parameter int BEAT_DIV = 25000000,
  parameter int GAP_CYC  = 2500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [AW-1:0]     last,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [TONE_W-1:0] wr_tone,
  output logic [AW-1:0]     beatnum,
  output logic [TONE_W-1:0] tone,
  output logic              tone_en,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(BEAT_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BEAT_DIV - 1);
  localparam logic [CW:0] ON_CYC = (CW + 1)'(BEAT_DIV - GAP_CYC);
  typedef enum logic {IDLE, PLAY} state_t;
  state_t state, state_n;
  logic [TONE_W-1:0] mem [2**AW];
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] last_q, last_n, beat_n;
  logic [TONE_W-1:0] tone_n;
  logic done_n;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_tone;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      beatnum <= '0;
      tone    <= '0;
      done    <= 1'b0;
      last_q  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      beatnum <= beat_n;
      tone    <= tone_n;
      done    <= done_n;
      last_q  <= last_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    beat_n  = beatnum;
    tone_n  = tone;
    done_n  = 1'b0;
    last_n  = last_q;
    if (state == IDLE) begin
      if (start && !stop) begin
        state_n = PLAY;
        last_n  = last;
        beat_n  = '0;
        cnt_n   = '0;
        tone_n  = mem[0];
      end
    end else if (stop) begin
      state_n = IDLE;
      cnt_n   = '0;
      beat_n  = '0;
      tone_n  = '0;
    end else if (cnt == CNT_MAX) begin
      cnt_n = '0;
      if (beatnum < last_q) begin
        beat_n = beatnum + AW'(1);
        tone_n = mem[beatnum + AW'(1)];
      end else begin
        done_n = 1'b1;
        beat_n = '0;
`ifdef BEAT_SEQ_LOOP_EN
        tone_n = mem[0];
`else
        state_n = IDLE;
        tone_n  = '0;
`endif
      end
    end else begin
      cnt_n = cnt + CW'(1);
    end
  end
  // speaker gating comes purely from registers, so inputs never reach the pin combinationally
  assign busy    = state == PLAY;
  assign tone_en = busy && tone != '0 && {1'b0, cnt} < ON_CYC;
endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Parametrised, self-timed successor to the combinational beat-to-tone lookup. Holds a writable melody table, advances the beat index from a programmable tempo divider, and drives a registered tone frequency plus a speaker-enable with a configurable articulation gap, so repeated notes stay distinguishable. Sits between the control FSM (start/stop, table load) and the PWM tone generator feeding the PMOD audio pin.

## Interface
- AW, 6, table address width; depth = 2**AW beats
- TONE_W, 32, tone frequency width (Hz)
- BEAT_DIV, 25000000, clock cycles per beat (≥2)
- GAP_CYC, 2500000, silent cycles at end of each beat (0 ≤ GAP_CYC < BEAT_DIV)

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin playback from beat 0 (pulse)
- stop  in  1  abort playback (pulse)
- last  in  AW  index of final beat; sampled on accepted start
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table write address
- wr_tone  in  TONE_W  tone to write; 0 = rest
- beatnum  out  AW  current beat index
- tone  out  TONE_W  current tone frequency
- tone_en  out  1  speaker enable (PMOD)
- busy  out  1  high while playing
- done  out  1  one-cycle pulse at natural end of song

## Operation
- States: IDLE, PLAY.
- Reset: state IDLE; beatnum, tone, tone_en, busy, done all 0; beat counter cnt = 0. Table contents not reset; software writes before playing.
- Table write: any cycle wr_en=1 stores wr_tone at wr_addr, in either state.
- IDLE: start=1 and stop=0 → PLAY; latch last; beatnum=0, cnt=0, tone=table[0], busy=1.
- PLAY: cnt increments each cycle; at cnt=BEAT_DIV-1, cnt→0 and:
  - beatnum<last_latched: beatnum+1, tone=table[beatnum+1].
  - beatnum=last_latched: end-of-song (see Configuration).
- tone latched only at beat boundaries; write to the currently playing address takes effect at its next occurrence.
- tone_en = busy && tone≠0 && cnt < BEAT_DIV-GAP_CYC; decoded from registered state only, no input-to-output combinational path.
- stop=1 in PLAY → IDLE next cycle; beatnum, tone, tone_en, busy → 0; done stays 0.
- start in PLAY ignored. start and stop in same cycle: stop wins (IDLE remains IDLE).
- last=0 legal: single-beat song.

## Timing
- start accepted in cycle t → busy, beatnum=0, tone=table[0] visible at t+1.
- Each beat lasts exactly BEAT_DIV cycles; tone_en high first BEAT_DIV-GAP_CYC cycles, low last GAP_CYC.
- Natural end, no loop: at final boundary (t+1+(last+1)·BEAT_DIV) state IDLE, busy=0, tone=0, beatnum=0, done=1 for that one cycle.
- stop latency: 1 cycle. rst_n assertion clears outputs immediately, regardless of state.

## Configuration
- BEAT_SEQ_LOOP_EN defined: at end of final beat, beatnum→0, tone=table[0], busy stays 1, done pulses 1 cycle per completed pass; playback continues until stop.
- Not defined: end of final beat returns to IDLE as in Timing; done pulses once.

## Test plan
Bench parameters: AW=3, BEAT_DIV=8, GAP_CYC=2.
- Reset mid-PLAY (rst_n low at beat 2): beatnum, tone, tone_en, busy, done read 0 same cycle; stay IDLE after release with no start.
- Table {262,262,262,0,294}, last=4, start, no loop: tone 262 for 24 cycles with tone_en pattern 6 high/2 low ×3, beat 3 tone=0 tone_en=0 for 8 cycles, beat 4 tone=294; done=1 exactly 41 cycles after start, busy=0 after.
- Same table with BEAT_SEQ_LOOP_EN: after beat 4, beatnum=0, tone=262, busy=1, done one-cycle pulse every 40 cycles.
- stop at beat 2, cnt=3: next cycle IDLE, tone=0, tone_en=0, done never asserted.
- start+stop same cycle in IDLE → busy stays 0; start during PLAY at beat 1 → beatnum sequence unaffected.
- Loop mode, write table[1]=330 during beat 1: beat 1 keeps tone=262; beat 1 of next pass shows 330.
